pad_mem_port: RTL
=================

Name: pad_mem_port

Overview:
Memory-side responder for the pad/testbench staging packet interface. It accepts `tb_packet_t` write and read requests while `pad_en` is high. Writes merge a `TX_DATA_WIDTH` slice into one `MAX_COLS`-wide row of the main bank using read-modify-write. Reads return the addressed slice. It drives the four-phase `mem_ack_out`/`mem_busy_out` handshake and sits between the pad pins and the main bank's single port, ahead of the core arbiter.

Parameters:
- MAX_COLS, 160: row width in bits (one bank word).
- TX_DATA_WIDTH, 32: slice width per packet.
- BANK_DEPTH, 160: number of rows.
- BANK_ADDR_WIDTH, $clog2(BANK_DEPTH): row address width.
- COL_ADDR_WIDTH, $clog2(MAX_COLS): column address width.

Ports:
- clock, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- pad_en, in, 1: request qualifier from pads.
- tb_packet_in, in, tb_packet_t: fields row_addr, col_addr, partial_vec, write_en, read_en, staging.
- mem_ack_out, out, 1: four-phase acknowledge.
- mem_busy_out, out, 1: transaction in flight.
- rd_vec_out, out, TX_DATA_WIDTH: read slice; valid while mem_ack_out is high after a read.
- err_out, out, 1: sticky; set on an out-of-range row request.
- bank_addr_out, out, BANK_ADDR_WIDTH: bank address.
- bank_rd_en_out, out, 1: bank read strobe; data returns the next cycle.
- bank_rd_data_in, in, MAX_COLS: bank read data.
- bank_wr_en_out, out, 1: bank write strobe.
- bank_wr_data_out, out, MAX_COLS: bank write data.
- port_owns_bank_out, out, 1: high whenever state is not IDLE; the arbiter blocks the core while this is high.

Behaviour:
- Reset values: all outputs 0; state IDLE; err_out 0; rd_vec_out 0.
- Reset mid-operation returns to IDLE the next cycle. A write strobe issued before reset stands; no later strobe is issued.
- A request is `req = pad_en & tb_packet_in.staging & (write_en | read_en)`.
- If write_en and read_en are both high, the write wins and the read is ignored.
- If staging is 0, requests are ignored and the block stays in IDLE.
- Column base: `col_base = col_addr` rounded down to a TX_DATA_WIDTH multiple. Misaligned low bits are ignored.
- Tail slice: bits at or above MAX_COLS are dropped on write and return 0 on read.
- Row and column fields are latched on acceptance. Later changes to the packet have no effect.

State machine:
- IDLE: when req is seen:
  - If row_addr >= BANK_DEPTH: set err_out and go to ACK. No bank access.
  - Otherwise: issue bank_rd_en_out=1 with bank_addr_out=row, latch the operation, go to RD_WAIT. mem_busy_out rises this cycle.
- RD_WAIT (one cycle): capture bank_rd_data_in.
  - Write: go to WR.
  - Read: load rd_vec_out with the addressed slice, go to ACK.
- WR: issue bank_wr_en_out=1, bank_addr_out=row, and bank_wr_data_out = captured row with the slice replaced by partial_vec. Go to ACK.
- ACK: mem_ack_out=1 and mem_busy_out=1. Stay here while `pad_en & (write_en | read_en)`. When the request drops, go to IDLE next cycle; mem_ack_out and mem_busy_out fall together.

Latency:
- Write: request seen at cycle 0; write strobe at cycle 2; ack high from cycle 3.
- Read: ack high from cycle 2.
- Back-to-back requests need at least one IDLE cycle between them.

Bank timing: bank_rd_en_out and bank_wr_en_out are never high in the same cycle. Each is a single-cycle strobe.

Decomposition:
- aoc4.svh holds: `tb_packet_t`, MAX_COLS, TX_DATA_WIDTH, BANK_DEPTH, BANK_ADDR_WIDTH, COL_ADDR_WIDTH, and the state enum `pad_port_state_t` (IDLE, RD_WAIT, WR, ACK).
- One combinational sub-module, `slice_merge`: inputs are the row, col_base and slice; outputs are the merged row and the extracted slice, with tail masking.
- The FSM stays in pad_mem_port.

Test Plan:
- Reset: all outputs 0.
- Write, row 3, col 0, vec 0x0000_00F5, into a zero bank: one write strobe at cycle 2 with addr 3 and data bits[7:0]=0xF5. Ack rises at cycle 3, holds until write_en drops, then ack and busy fall the next cycle.
- Second write to row 3, col 32, vec 0x1 after the first: bank row 3 = bit32 set | 0xF5; bits 0-7 preserved.
- Tail write, col 128, vec 0xFFFF_FFFF, MAX_COLS=140: row bits 128-139 set; no bits beyond 139 written. A readback at col 128 returns 0x0000_0FFF.
- Row 200: no bank strobes; err_out=1; ack still completes the four-phase handshake.
- Request with staging=0 or pad_en=0: no response for 10 cycles.
- Reset asserted in RD_WAIT of a write: no write strobe issued; next cycle state is IDLE and ack/busy are 0.
- write_en and read_en both high: the write is performed and rd_vec_out is unchanged.

Source files
------------

// File: rtl/pad_mem_port_pkg.sv
// rtl/pad_mem_port_pkg.sv - shared sizes, packet type and state encoding for the pad memory port
package pad_mem_port_pkg;

    localparam int MAX_COLS        = 160;
    localparam int TX_DATA_WIDTH   = 32;
    localparam int BANK_DEPTH      = 160;
    localparam int BANK_ADDR_WIDTH = $clog2(BANK_DEPTH);
    localparam int COL_ADDR_WIDTH  = $clog2(MAX_COLS);

    typedef struct packed {
        logic [BANK_ADDR_WIDTH-1:0] row_addr;
        logic [COL_ADDR_WIDTH-1:0]  col_addr;
        logic [TX_DATA_WIDTH-1:0]   partial_vec;
        logic                       write_en;
        logic                       read_en;
        logic                       staging;
    } tb_packet_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR      = 2'd2,
        ACK     = 2'd3
    } pad_port_state_t;

    // Slices always start on a slice-width boundary; low column bits are discarded.
    function automatic logic [COL_ADDR_WIDTH-1:0] col_base_of(input logic [COL_ADDR_WIDTH-1:0] col_addr);
        return col_addr & ~COL_ADDR_WIDTH'(TX_DATA_WIDTH - 1);
    endfunction

endpackage

// File: rtl/slice_merge.sv
// rtl/slice_merge.sv - inserts or extracts one slice of a bank row, dropping columns past the row end
module slice_merge
    import pad_mem_port_pkg::*;
#(
    parameter int COLS = MAX_COLS
) (
    input  logic [COLS-1:0]           row_in,
    input  logic [COL_ADDR_WIDTH-1:0] col_base,
    input  logic [TX_DATA_WIDTH-1:0]  slice_in,
    output logic [COLS-1:0]           merged_row,
    output logic [TX_DATA_WIDTH-1:0]  slice_out
);

    logic [COLS-1:0] slice_mask;
    logic [COLS-1:0] slice_data;

    // Shifting inside a row-wide vector lets tail bits fall off the top on write
    // and shifts zeros in from above on read.
    always_comb begin
        slice_mask = COLS'({TX_DATA_WIDTH{1'b1}}) << col_base;
        slice_data = COLS'(slice_in) << col_base;
        merged_row = (row_in & ~slice_mask) | (slice_data & slice_mask);
        slice_out  = TX_DATA_WIDTH'(row_in >> col_base);
    end

endmodule

// File: rtl/pad_mem_port.sv
// rtl/pad_mem_port.sv - pad-side staging responder doing slice read and read-modify-write on the main bank
module pad_mem_port
    import pad_mem_port_pkg::*;
#(
    parameter int COLS  = MAX_COLS,
    parameter int DEPTH = BANK_DEPTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       pad_en,
    input  tb_packet_t                 tb_packet_in,
    output logic                       mem_ack_out,
    output logic                       mem_busy_out,
    output logic [TX_DATA_WIDTH-1:0]   rd_vec_out,
    output logic                       err_out,
    output logic [BANK_ADDR_WIDTH-1:0] bank_addr_out,
    output logic                       bank_rd_en_out,
    input  logic [COLS-1:0]            bank_rd_data_in,
    output logic                       bank_wr_en_out,
    output logic [COLS-1:0]            bank_wr_data_out,
    output logic                       port_owns_bank_out
);

    pad_port_state_t state;
    pad_port_state_t state_next;

    logic                       req;
    logic                       req_hold;
    logic                       row_oob;
    logic                       op_write_q;
    logic [BANK_ADDR_WIDTH-1:0] row_q;
    logic [COL_ADDR_WIDTH-1:0]  col_base_q;
    logic [TX_DATA_WIDTH-1:0]   vec_q;
    logic [COLS-1:0]            row_data_q;
    logic [COLS-1:0]            merge_row_in;
    logic [COLS-1:0]            merged_row;
    logic [TX_DATA_WIDTH-1:0]   slice_out;

    assign req      = pad_en & tb_packet_in.staging & (tb_packet_in.write_en | tb_packet_in.read_en);
    // The acknowledge phase ignores staging: only the pads dropping the request releases it.
    assign req_hold = pad_en & (tb_packet_in.write_en | tb_packet_in.read_en);
    assign row_oob  = int'(tb_packet_in.row_addr) >= DEPTH;

    // Read data arrives during RD_WAIT; the write merge later works from the captured copy.
    assign merge_row_in = (state == RD_WAIT) ? bank_rd_data_in : row_data_q;

    slice_merge #(
        .COLS (COLS)
    ) u_slice_merge (
        .row_in     (merge_row_in),
        .col_base   (col_base_q),
        .slice_in   (vec_q),
        .merged_row (merged_row),
        .slice_out  (slice_out)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req) begin
                    state_next = row_oob ? ACK : RD_WAIT;
                end
            end
            RD_WAIT: state_next = op_write_q ? WR : ACK;
            WR:      state_next = ACK;
            ACK: begin
                if (!req_hold) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_write_q <= 1'b0;
            row_q      <= '0;
            col_base_q <= '0;
            vec_q      <= '0;
            row_data_q <= '0;
            rd_vec_out <= '0;
            err_out    <= 1'b0;
        end else begin
            if (state == IDLE && req) begin
                op_write_q <= tb_packet_in.write_en;
                row_q      <= tb_packet_in.row_addr;
                col_base_q <= col_base_of(tb_packet_in.col_addr);
                vec_q      <= tb_packet_in.partial_vec;
                if (row_oob) begin
                    err_out <= 1'b1;
                end
            end
            if (state == RD_WAIT) begin
                row_data_q <= bank_rd_data_in;
                if (!op_write_q) begin
                    rd_vec_out <= slice_out;
                end
            end
        end
    end

    // Outputs are forced low while reset is held so no strobe escapes mid-reset.
    always_comb begin
        mem_ack_out        = 1'b0;
        mem_busy_out       = 1'b0;
        bank_addr_out      = '0;
        bank_rd_en_out     = 1'b0;
        bank_wr_en_out     = 1'b0;
        bank_wr_data_out   = '0;
        port_owns_bank_out = 1'b0;
        if (!reset) begin
            port_owns_bank_out = (state != IDLE);
            case (state)
                IDLE: begin
                    if (req) begin
                        mem_busy_out = 1'b1;
                        if (!row_oob) begin
                            bank_rd_en_out = 1'b1;
                            bank_addr_out  = tb_packet_in.row_addr;
                        end
                    end
                end
                RD_WAIT: begin
                    mem_busy_out  = 1'b1;
                    bank_addr_out = row_q;
                end
                WR: begin
                    mem_busy_out     = 1'b1;
                    bank_wr_en_out   = 1'b1;
                    bank_addr_out    = row_q;
                    bank_wr_data_out = merged_row;
                end
                ACK: begin
                    mem_ack_out  = 1'b1;
                    mem_busy_out = 1'b1;
                end
                default: begin
                    mem_busy_out = 1'b0;
                end
            endcase
        end
    end

endmodule
